bcd_timer_core: RTL and testbench
=================================

# bcd_timer_core

Parametrised countdown/stopwatch engine that generalises the egg‑timer sequencing into one reusable core. Keeps an MM:SS value as four BCD digits, counts down (egg timer) or up (stopwatch) at 1 Hz from the system clock, and raises a timed alarm. Sits between the `key_press` debouncers/switch inputs and the `dec2_7seg` displays in the board top level. Replaces the hard‑wired MM:SS logic in the sequence detector.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; one second = CLK_HZ cycles (≥4).
- `MAX_MINUTES`, 99: highest minutes value, 1..99; applies to load clamp and count‑up ceiling.
- `ALARM_SECS`, 10: alarm duration in seconds, 1..255.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active‑high; overrides everything.
- `load`  in  1  one‑cycle pulse; load `load_min_bcd`/`load_sec_bcd`.
- `start_stop`  in  1  one‑cycle pulse; start, pause, resume.
- `clear`  in  1  one‑cycle pulse; abort to IDLE, digits zeroed.
- `mode`  in  1  0 = count down, 1 = count up; latched on start from IDLE.
- `load_min_bcd`  in  8  {tens, ones} minutes, BCD.
- `load_sec_bcd`  in  8  {tens, ones} seconds, BCD.
- `ones_sec`, `tens_sec`, `ones_min`, `tens_min`  out  4 each  registered BCD digits.
- `state`  out  4  current state code, for the HEX5 display.
- `running`  out  1  high in RUN.
- `alarm`  out  1  alarm indicator (see Configuration).
- `expired`  out  1  one‑cycle pulse on entry to ALARM.

## Operation
- States (codes): IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- Reset: state IDLE, digits 0, latched mode 0, prescaler 0, alarm counter 0, all outputs 0.
- Same‑cycle priority: reset > clear > load > start_stop. Lower‑priority pulses in that cycle are dropped.
- clear: any state → IDLE, all digits 0.
- load: accepted in IDLE or PAUSE, ignored in RUN/ALARM.
  - Clamping: each ones digit >9 → 9. Minutes >MAX_MINUTES → MAX_MINUTES. Seconds >59 → 59.
  - Loading in PAUSE keeps PAUSE.
- start_stop transitions:
  - IDLE → RUN and latch `mode`. Ignored if mode=0 and value is 00:00, or if mode=1 and value is already MAX_MINUTES:59.
  - RUN → PAUSE.
  - PAUSE → RUN, using the latched mode.
  - ALARM → IDLE (acknowledge).
- Tick: the prescaler counts 0..CLK_HZ‑1 in RUN and ALARM, holds its value in PAUSE, and is 0 in IDLE. A tick occurs when the prescaler wraps.
- Down count on tick: decrement with BCD borrow (ss 00 → 59 with minute decrement). A tick that produces 00:00 moves to ALARM in the same edge.
- Up count on tick: increment with BCD carry (59 → 00 with minute increment). A tick that produces MAX_MINUTES:59 moves to ALARM in the same edge.
- ALARM: digits frozen. Entry zeroes the prescaler and the alarm counter. After ALARM_SECS ticks → IDLE; digits keep the final value.
- `mode` changes outside the IDLE→RUN start have no effect.

## Timing
- All outputs are registered and change on the edge that accepts the command. No combinational input‑to‑output paths.
- First tick occurs CLK_HZ cycles after start is accepted from IDLE. Resume from PAUSE continues from the held prescaler count.
- `expired` is high for exactly the cycle after the ALARM‑entry edge; `state`=3 in that same cycle.
- ALARM lasts ALARM_SECS×CLK_HZ cycles unless acknowledged or cleared.

## Configuration
- `TIMER_ALARM_BLINK_EN` defined: in ALARM, `alarm` is high while prescaler < CLK_HZ/2, giving a 1 Hz, 50 % blink starting high.
- `TIMER_ALARM_BLINK_EN` undefined: `alarm` is steady high throughout ALARM.
- `alarm` is 0 outside ALARM in both builds.

## Structure
- Package `timer_pkg` holds:
  - state encodings IDLE/RUN/PAUSE/ALARM as 4‑bit constants;
  - BCD digit typedef (4 bits);
  - `BCD_MAX_SEC` = 59.
- Sub‑module `tick_gen` holds the prescaler. Inputs: `clock`, `reset`, `run`, `hold`, `zero`. Outputs: `tick` and the current count (needed for blink).
- BCD increment/decrement and load clamping are functions in `timer_pkg`.

## Test plan
All scenarios use CLK_HZ=10, MAX_MINUTES=99, ALARM_SECS=3.
- Load 00:03, mode 0, start → digits 00:02/00:01/00:00 at 10/20/30 cycles after start. At 00:00: state 3, `expired` one pulse, ALARM ends after 30 more cycles with digits 00:00.
- Load 01:00, mode 0, run 1 tick → 00:59. Load 99:59 in up mode, start → ALARM at the first tick without changing value? No: start is ignored (stays IDLE).
- Load 5A:7F → clamps to 59:59. Load 00:00 mode 0, start → stays IDLE.
- Start at 00:05, pause after 15 cycles for 100 cycles, resume → next tick occurs 5 cycles after resume; value 00:03.
- Mode 1 from 98:58 → 98:59, then 99:00, …, ALARM at 99:59.
- Same cycle as a tick in RUN: clear+start_stop → IDLE, 00:00. Load during RUN → ignored. Reset asserted during ALARM → all outputs 0 on the next edge. Check `alarm` blink/steady behaviour in both macro builds.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, state codes and BCD helpers for the MM:SS timer core.
package timer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RUN   = 4'd1,
        ST_PAUSE = 4'd2,
        ST_ALARM = 4'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Field order makes the packed value read as MMSS in hex.
    typedef struct packed {
        bcd_t tens_min;
        bcd_t ones_min;
        bcd_t tens_sec;
        bcd_t ones_sec;
    } mmss_t;

    localparam int BCD_MAX_SEC = 59;

    // Ceiling value MAX_MINUTES:59.
    function automatic mmss_t mmss_max(input int max_min);
        mmss_t r;
        r.tens_min = bcd_t'(max_min / 10);
        r.ones_min = bcd_t'(max_min % 10);
        r.tens_sec = bcd_t'(BCD_MAX_SEC / 10);
        r.ones_sec = bcd_t'(BCD_MAX_SEC % 10);
        return r;
    endfunction

    // One second forward with BCD carry; the caller stops before overflow.
    function automatic mmss_t bcd_inc(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.ones_sec != 4'd9) begin
            r.ones_sec = v.ones_sec + 4'd1;
        end else begin
            r.ones_sec = 4'd0;
            if (v.tens_sec != 4'd5) begin
                r.tens_sec = v.tens_sec + 4'd1;
            end else begin
                r.tens_sec = 4'd0;
                if (v.ones_min != 4'd9) begin
                    r.ones_min = v.ones_min + 4'd1;
                end else begin
                    r.ones_min = 4'd0;
                    r.tens_min = v.tens_min + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // One second back with BCD borrow; never called on 00:00.
    function automatic mmss_t bcd_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.ones_sec != 4'd0) begin
            r.ones_sec = v.ones_sec - 4'd1;
        end else begin
            r.ones_sec = 4'd9;
            if (v.tens_sec != 4'd0) begin
                r.tens_sec = v.tens_sec - 4'd1;
            end else begin
                r.tens_sec = 4'd5;
                if (v.ones_min != 4'd0) begin
                    r.ones_min = v.ones_min - 4'd1;
                end else begin
                    r.ones_min = 4'd9;
                    r.tens_min = v.tens_min - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Ones digits saturate at 9 first, then each field saturates at its maximum.
    function automatic mmss_t bcd_clamp(input logic [7:0] min_bcd,
                                        input logic [7:0] sec_bcd,
                                        input int max_min);
        mmss_t r;
        bcd_t  mo, so;
        int    m, s;
        mo = (min_bcd[3:0] > 4'd9) ? 4'd9 : min_bcd[3:0];
        so = (sec_bcd[3:0] > 4'd9) ? 4'd9 : sec_bcd[3:0];
        m  = int'(min_bcd[7:4]) * 10 + int'(mo);
        s  = int'(sec_bcd[7:4]) * 10 + int'(so);
        if (m > max_min) begin
            r.tens_min = bcd_t'(max_min / 10);
            r.ones_min = bcd_t'(max_min % 10);
        end else begin
            r.tens_min = min_bcd[7:4];
            r.ones_min = mo;
        end
        if (s > BCD_MAX_SEC) begin
            r.tens_sec = bcd_t'(BCD_MAX_SEC / 10);
            r.ones_sec = bcd_t'(BCD_MAX_SEC % 10);
        end else begin
            r.tens_sec = sec_bcd[7:4];
            r.ones_sec = so;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts while running, freezes on hold, else sits at 0.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             hold,
    input  logic             zero,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick  = run && (count_q == LAST);
    assign count = count_q;

    // Next prescaler value: zero wins, then run/wrap, then hold, else idle at 0.
    always_comb begin
        count_d = count_q;
        if (zero) begin
            count_d = '0;
        end else if (run) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end else if (!hold) begin
            count_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/bcd_timer_core.sv
// MM:SS countdown / stopwatch engine with timed alarm.
// Build option: TIMER_ALARM_BLINK_EN makes `alarm` blink at 1 Hz instead of holding steady.
module bcd_timer_core
    import timer_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int MAX_MINUTES = 99,
    parameter int ALARM_SECS  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       mode,
    input  logic [7:0] load_min_bcd,
    input  logic [7:0] load_sec_bcd,
    output logic [3:0] ones_sec,
    output logic [3:0] tens_sec,
    output logic [3:0] ones_min,
    output logic [3:0] tens_min,
    output logic [3:0] state,
    output logic       running,
    output logic       alarm,
    output logic       expired
);

    localparam int    CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam mmss_t MAX_VAL = mmss_max(MAX_MINUTES);

    state_t           state_q, state_d;
    mmss_t            digits_q, digits_d;
    logic             mode_q, mode_d;
    logic [7:0]       alarm_cnt_q, alarm_cnt_d;
    logic             running_q, running_d;
    logic             alarm_q, alarm_d;
    logic             expired_q, expired_d;

    logic             tick;
    logic [CNT_W-1:0] presc_cnt;
    logic             presc_zero;
    logic             start_ok;
    mmss_t            stepped, final_val, loaded;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .run   ((state_q == ST_RUN) || (state_q == ST_ALARM)),
        .hold  (state_q == ST_PAUSE),
        .zero  (presc_zero),
        .tick  (tick),
        .count (presc_cnt)
    );

    // Next-state, digit and alarm-counter logic; clear > load > start_stop.
    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        mode_d      = mode_q;
        alarm_cnt_d = alarm_cnt_q;
        stepped     = mode_q ? bcd_inc(digits_q) : bcd_dec(digits_q);
        final_val   = mode_q ? MAX_VAL : '0;
        loaded      = bcd_clamp(load_min_bcd, load_sec_bcd, MAX_MINUTES);
        start_ok    = mode ? (digits_q != MAX_VAL) : (digits_q != '0);
        if (clear) begin
            state_d  = ST_IDLE;
            digits_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        digits_d = loaded;
                    end else if (start_stop && start_ok) begin
                        state_d = ST_RUN;
                        mode_d  = mode;
                    end
                end
                ST_RUN: begin
                    // A tick reaching the end value wins over a pause request.
                    if (tick) digits_d = stepped;
                    if (tick && (stepped == final_val)) state_d = ST_ALARM;
                    else if (start_stop && !load)       state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (load)            digits_d = loaded;
                    else if (start_stop) state_d  = ST_RUN;
                end
                ST_ALARM: begin
                    if (start_stop && !load) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        if (alarm_cnt_q == 8'(ALARM_SECS - 1)) state_d = ST_IDLE;
                        else alarm_cnt_d = alarm_cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if ((state_d == ST_ALARM) && (state_q != ST_ALARM)) alarm_cnt_d = '0;
        presc_zero = (state_d != state_q) && ((state_d == ST_IDLE) || (state_d == ST_ALARM));
        running_d  = (state_d == ST_RUN);
        expired_d  = (state_d == ST_ALARM) && (state_q != ST_ALARM);
    end

`ifdef TIMER_ALARM_BLINK_EN
    logic [CNT_W-1:0] presc_nxt;
    // Blink from the prescaler value the next cycle will see, so it starts high on entry.
    always_comb begin
        presc_nxt = (presc_zero || tick) ? '0 : presc_cnt + 1'b1;
        alarm_d   = (state_d == ST_ALARM) && (presc_nxt < CNT_W'(CLK_HZ / 2));
    end
`else
    logic presc_unused;
    assign presc_unused = ^presc_cnt;  // count only feeds the blink build
    // Steady alarm for the whole ALARM state.
    always_comb begin
        alarm_d = (state_d == ST_ALARM);
    end
`endif

    // State, digits and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            digits_q    <= '0;
            mode_q      <= 1'b0;
            alarm_cnt_q <= '0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            mode_q      <= mode_d;
            alarm_cnt_q <= alarm_cnt_d;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
            expired_q   <= expired_d;
        end
    end

    assign ones_sec = digits_q.ones_sec;
    assign tens_sec = digits_q.tens_sec;
    assign ones_min = digits_q.ones_min;
    assign tens_min = digits_q.tens_min;
    assign state    = state_q;
    assign running  = running_q;
    assign alarm    = alarm_q;
    assign expired  = expired_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Directed bench for bcd_timer_core at CLK_HZ=10, MAX_MINUTES=99, ALARM_SECS=3.
module tb_bcd_timer_core;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0, start_stop = 1'b0, clear = 1'b0, mode = 1'b0;
    logic [7:0] load_min_bcd = 8'h00, load_sec_bcd = 8'h00;
    logic [3:0] ones_sec, tens_sec, ones_min, tens_min, state;
    logic       running, alarm, expired;
    logic [15:0] digits;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef TIMER_ALARM_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    bcd_timer_core #(
        .CLK_HZ      (10),
        .MAX_MINUTES (99),
        .ALARM_SECS  (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .start_stop   (start_stop),
        .clear        (clear),
        .mode         (mode),
        .load_min_bcd (load_min_bcd),
        .load_sec_bcd (load_sec_bcd),
        .ones_sec     (ones_sec),
        .tens_sec     (tens_sec),
        .ones_min     (ones_min),
        .tens_min     (tens_min),
        .state        (state),
        .running      (running),
        .alarm        (alarm),
        .expired      (expired)
    );

    always #5 clock = ~clock;

    assign digits = {tens_min, ones_min, tens_sec, ones_sec};

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load_min_bcd = m;
        load_sec_bcd = s;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_digits", digits, 16'h0000);
        chk("rst_state", 16'(state), 16'h0);
        chk("rst_flags", {13'd0, running, alarm, expired}, 16'h0);
        reset = 1'b0;
        cyc(1);

        // Countdown 00:03 through ALARM
        do_load(8'h00, 8'h03);
        chk("ld_0003", digits, 16'h0003);
        mode = 1'b0;
        do_ss();
        chk("start_state", 16'(state), 16'h1);
        chk("start_running", 16'(running), 16'h1);
        cyc(9);
        chk("pre_tick", digits, 16'h0003);
        cyc(1);
        chk("tick1", digits, 16'h0002);
        cyc(10);
        chk("tick2", digits, 16'h0001);
        cyc(10);
        chk("tick3", digits, 16'h0000);
        chk("alarm_state", 16'(state), 16'h3);
        chk("expired_hi", 16'(expired), 16'h1);
        chk("alarm_entry", 16'(alarm), 16'h1);
        chk("alarm_running", 16'(running), 16'h0);
        cyc(1);
        chk("expired_lo", 16'(expired), 16'h0);
        chk("alarm_state2", 16'(state), 16'h3);
        cyc(4);
        chk("alarm_half", 16'(alarm), BLINK ? 16'h0 : 16'h1);
        cyc(24);
        chk("alarm_end_m1", 16'(state), 16'h3);
        cyc(1);
        chk("alarm_end", 16'(state), 16'h0);
        chk("alarm_end_dig", digits, 16'h0000);
        chk("alarm_end_flag", 16'(alarm), 16'h0);

        // Minute borrow
        do_load(8'h01, 8'h00);
        do_ss();
        cyc(10);
        chk("borrow", digits, 16'h0059);
        do_clear();
        chk("clr_state", 16'(state), 16'h0);
        chk("clr_digits", digits, 16'h0000);

        // Start refused at the up-count ceiling and at 00:00 down
        do_load(8'h99, 8'h59);
        mode = 1'b1;
        do_ss();
        chk("up_max_refused", 16'(state), 16'h0);
        chk("up_max_digits", digits, 16'h9959);
        do_load(8'h5A, 8'h7F);
        chk("clamp_5A7F", digits, 16'h5959);
        do_load(8'hA5, 8'h3C);
        chk("clamp_A53C", digits, 16'h9939);
        do_load(8'h00, 8'h00);
        mode = 1'b0;
        do_ss();
        chk("zero_refused", 16'(state), 16'h0);

        // Pause / resume keeps prescaler phase; load in PAUSE
        do_load(8'h00, 8'h05);
        do_ss();
        cyc(14);
        do_ss();
        chk("pause_state", 16'(state), 16'h2);
        chk("pause_digits", digits, 16'h0004);
        cyc(100);
        chk("pause_hold", digits, 16'h0004);
        do_ss();
        chk("resume_state", 16'(state), 16'h1);
        cyc(4);
        chk("resume_pre", digits, 16'h0004);
        cyc(1);
        chk("resume_tick", digits, 16'h0003);
        do_ss();
        do_load(8'h01, 8'h20);
        chk("pause_load", digits, 16'h0120);
        chk("pause_load_st", 16'(state), 16'h2);
        do_clear();

        // Up count 98:58 to ceiling; mode change after start ignored
        do_load(8'h98, 8'h58);
        mode = 1'b1;
        do_ss();
        mode = 1'b0;
        cyc(10);
        chk("up_1", digits, 16'h9859);
        cyc(10);
        chk("up_carry", digits, 16'h9900);
        cyc(580);
        chk("up_near", digits, 16'h9958);
        chk("up_near_st", 16'(state), 16'h1);
        cyc(10);
        chk("up_ceiling", digits, 16'h9959);
        chk("up_alarm_st", 16'(state), 16'h3);
        chk("up_expired", 16'(expired), 16'h1);
        do_ss();
        chk("ack_state", 16'(state), 16'h0);
        chk("ack_alarm", 16'(alarm), 16'h0);
        chk("ack_digits", digits, 16'h9959);

        // clear + start_stop on a tick edge
        do_load(8'h00, 8'h05);
        mode = 1'b0;
        do_ss();
        cyc(9);
        clear = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        clear = 1'b0;
        start_stop = 1'b0;
        chk("clr_tick_st", 16'(state), 16'h0);
        chk("clr_tick_dig", digits, 16'h0000);
        chk("clr_tick_run", 16'(running), 16'h0);

        // Load ignored in RUN, then reset during ALARM
        do_load(8'h00, 8'h05);
        do_ss();
        cyc(3);
        do_load(8'h00, 8'h30);
        chk("run_load_ign", digits, 16'h0005);
        chk("run_load_st", 16'(state), 16'h1);
        cyc(6);
        chk("run_load_tick", digits, 16'h0004);
        cyc(40);
        chk("run_alarm", 16'(state), 16'h3);
        chk("run_alarm_flag", 16'(alarm), 16'h1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("alarm_rst_dig", digits, 16'h0000);
        chk("alarm_rst_st", 16'(state), 16'h0);
        chk("alarm_rst_fl", {13'd0, running, alarm, expired}, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
